// File: rtl/onehot_arbiter.sv
// Packet-locked round-robin arbiter: grants one requester at a time and holds the
// grant until its last word transfers, then advances the priority pointer.
// Valid/ready: a word moves when valid and ready are both high on a rising clk edge.
module onehot_arbiter #(
  parameter int Count = 4,
  parameter int Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Count-1:0]           req_valid_i,
  input  logic [Count-1:0]           req_last_i,
  input  logic [Width-1:0]           req_data_i [Count],
  output logic [Count-1:0]           req_ready_o,
  output logic                       out_valid_o,
  output logic                       out_last_o,
  output logic [Width-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [Count-1:0]           grant_o,
  output logic                       busy_o,
  output logic [$clog2(Count)-1:0]   dbg_ptr_o
);

  localparam int PtrW = $clog2(Count);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  idx_q, idx_d;
  logic [Count-1:0] grant_q, grant_d;

  logic             pick_found;
  logic [PtrW-1:0]  pick_idx;
  logic [Width-1:0] mux_data;
  logic             xfer_last;

  // First valid requester at or after ptr, wrapping from Count-1 back to 0.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = 0; k < Count; k++) begin
      j = int'(ptr_q) + k;
      if (j >= Count) j = j - Count;
      if (!pick_found && req_valid_i[j]) begin
        pick_found = 1'b1;
        pick_idx   = PtrW'(j);
      end
    end
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < Count; i++) begin
      mux_data = mux_data | (req_data_i[i] & {Width{grant_q[i]}});
    end
  end

  assign out_data_o  = mux_data;
  assign out_valid_o = |(req_valid_i & grant_q);
  assign out_last_o  = |(req_last_i & req_valid_i & grant_q);
  assign req_ready_o = grant_q & {Count{out_ready_i}};
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == LOCKED);
  assign dbg_ptr_o   = ptr_q;
  assign xfer_last   = out_valid_o && out_ready_i && out_last_o;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          idx_d   = pick_idx;
          grant_d = Count'(1) << pick_idx;
        end
      end
      LOCKED: begin
        // Release only on the last word; the bubble cycle comes from passing through IDLE.
        if (xfer_last) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == PtrW'(Count - 1)) ? '0 : idx_q + PtrW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_onehot_arbiter.sv
// Bench for onehot_arbiter (Count=4, Width=8): directed scenarios then random
// packet traffic, checked cycle by cycle against a packet-level reference model.
module tb_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [7:0] req_data [4];
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_last;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] grant;
  logic       busy;
  logic [1:0] dbg_ptr;

  onehot_arbiter #(.Count(4), .Width(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- sources, model, scoreboard ----------------
  logic [8:0] src_q [4][$];   // {last, data} words waiting at each requester
  bit         hold [4];       // force a requester's valid low
  bit         m_busy;
  int         m_ptr;
  int         m_owner;
  logic [7:0] exp_q [$];
  bit         sb_on;
  int         gl [$];         // observed grant order
  logic [3:0] prev_grant;
  int         errors;
  int         checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 4; i++) n += src_q[i].size();
    return n;
  endfunction

  function automatic int onehot_index(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int r, input int n);
    for (int w = 0; w < n; w++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      src_q[r].push_back({(w == n - 1), d});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = src_q[i][0][7:0];
        req_last[i]  = src_q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'($urandom_range(0, 255));
        req_last[i]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check();
    logic [3:0] e_grant, e_ready;
    logic       e_valid, e_last;
    logic [7:0] e_data;
    e_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e_valid = m_busy && req_valid[m_owner];
    e_last  = e_valid && req_last[m_owner];
    e_data  = m_busy ? req_data[m_owner] : 8'h00;
    e_ready = (m_busy && out_ready) ? e_grant : 4'b0000;
    chk("grant", grant, e_grant);
    chk("busy", busy, m_busy);
    chk("ptr", dbg_ptr, m_ptr[1:0]);
    chk("out_valid", out_valid, e_valid);
    chk("out_last", out_last, e_last);
    chk("out_data", out_data, e_data);
    chk("req_ready", req_ready, e_ready);
    chk("grant_onehot0", $onehot0(grant), 1'b1);
    chk("ready_subset", req_ready & ~grant, 4'b0000);
    if (grant == 4'b0000) chk("idle_data_zero", out_data, 8'h00);
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_word", out_data, 8'h00);
      else chk("sb_data", out_data, exp_q.pop_front());
    end
  endtask

  task automatic update();
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (m_busy) begin
      if (req_valid[m_owner] && out_ready) begin
        logic [8:0] w;
        w = src_q[m_owner].pop_front();
        if (w[8]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % 4;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!m_busy && req_valid[j]) begin
          m_busy  = 1'b1;
          m_owner = j;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    if (grant != 4'b0000 && prev_grant == 4'b0000) gl.push_back(onehot_index(grant));
    prev_grant = grant;
    check();
    update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pending() > 0 || m_busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", pending() + int'(m_busy), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    errors = 0; checks = 0; sb_on = 0;
    m_busy = 0; m_ptr = 0; m_owner = 0;
    prev_grant = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      hold[i] = 0;
      req_data[i] = 8'h00;
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", dbg_ptr, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_req_ready", req_ready, 4'b0000);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Round-robin: everyone requests single-word packets; requester 0 twice.
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1);
    gl.delete();
    drain(40);
    chk("rr_count", gl.size(), 5);
    for (int i = 0; i < 5 && i < gl.size(); i++) chk("rr_order", gl[i], i % 4);
    chk("rr_ptr", dbg_ptr, 2'd1);

    // Single requester, three-word packet.
    src_q[2].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b0, 8'h22});
    src_q[2].push_back({1'b1, 8'h33});
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    sb_on = 1;
    cycle();
    chk("single_grant_latency", grant, 4'b0100);
    drain(20);
    sb_on = 0;
    chk("single_sb_empty", exp_q.size(), 0);
    chk("single_ptr", dbg_ptr, 2'd3);
    chk("single_idle", busy, 1'b0);

    // Wrap from ptr 3: requesters 0 and 3.
    push_pkt(0, 1); push_pkt(3, 1);
    gl.delete();
    drain(20);
    chk("wrap_count", gl.size(), 2);
    if (gl.size() == 2) begin
      chk("wrap_first", gl[0], 3);
      chk("wrap_second", gl[1], 0);
    end
    chk("wrap_ptr", dbg_ptr, 2'd1);

    // Backpressure and valid stall on requester 1, others requesting meanwhile.
    push_pkt(1, 3); push_pkt(0, 1); push_pkt(2, 1); push_pkt(3, 2);
    cycle();
    cycle();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      drive();
      #1;
      chk("bp_ready_low", req_ready, 4'b0000);
      chk("bp_grant_held", grant, 4'b0010);
      chk("bp_data_stable", out_data, src_q[1][0][7:0]);
      cycle();
    end
    out_ready = 1'b1;
    hold[1] = 1;
    for (int s = 0; s < 2; s++) begin
      drive();
      #1;
      chk("stall_valid_low", out_valid, 1'b0);
      chk("stall_grant_held", grant, 4'b0010);
      cycle();
    end
    hold[1] = 0;
    drain(40);

    // Reset in the middle of a packet from requester 1.
    push_pkt(1, 3);
    cycle();
    cycle();
    chk("mid_pkt_grant", grant, 4'b0010);
    rst_n = 1'b0;
    #1;
    m_busy = 1'b0;
    m_ptr  = 0;
    chk("arst_grant", grant, 4'b0000);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_out_data", out_data, 8'h00);
    chk("arst_req_ready", req_ready, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ptr", dbg_ptr, 2'd0);
    src_q[1].delete();
    push_pkt(1, 1); push_pkt(0, 1);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_grant", grant, 4'b0001);
    drain(20);

    // Random traffic with backpressure and valid gaps.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = $urandom_range(0, 3);
        if (src_q[r].size() < 8) push_pkt(r, $urandom_range(1, 4));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) hold[i] = ($urandom_range(0, 7) == 0);
      cycle();
    end
    for (int i = 0; i < 4; i++) hold[i] = 0;
    out_ready = 1'b1;
    drain(500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
